product_list_manager: RTL and testbench

PRODUCT_LIST_MANAGER -- requirements
Module: product_list_manager

---
 rtl/product_list_manager_pkg.sv | 16 +
 rtl/product_list_manager_price_table.sv | 32 +++
 rtl/product_list_manager.sv | 150 +++++++++++++++
 tb/tb_product_list_manager.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/product_list_manager_pkg.sv
// Shared constants for the sale-display product list: slot geometry, field widths
// and the list controller state encoding.
package product_list_manager_pkg;

  localparam int SLOTS   = 12;
  localparam int SLOT_W  = 4;
  localparam int PRICE_W = 8;
  localparam int TOTAL_W = 12;
  localparam int COUNT_W = 4;

  localparam logic [SLOT_W-1:0] BLANK_ID = 4'hF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CLR  = 1'b1;

endpackage

// File: rtl/product_list_manager_price_table.sv
// Combinational per-ID price lookup; the blank code (and anything unlisted) prices at zero.
module price_table
  import product_list_manager_pkg::*;
(
  input  logic [SLOT_W-1:0]  id,
  output logic [PRICE_W-1:0] price
);

  // Fixed price list indexed by product ID
  always_comb begin
    price = 8'd0;
    case (id)
      4'd0:    price = 8'd10;
      4'd1:    price = 8'd25;
      4'd2:    price = 8'd40;
      4'd3:    price = 8'd55;
      4'd4:    price = 8'd99;
      4'd5:    price = 8'd120;
      4'd6:    price = 8'd7;
      4'd7:    price = 8'd200;
      4'd8:    price = 8'd33;
      4'd9:    price = 8'd64;
      4'd10:   price = 8'd128;
      4'd11:   price = 8'd150;
      4'd12:   price = 8'd1;
      4'd13:   price = 8'd180;
      4'd14:   price = 8'd255;
      default: price = 8'd0;
    endcase
  end

endmodule

// File: rtl/product_list_manager.sv
// Ordered product list for the sale display: append, drop-newest and clear, with
// a running price total kept alongside the slot contents.
module product_list_manager #(
  parameter int          SLOTS    = product_list_manager_pkg::SLOTS,
  parameter logic [3:0]  BLANK_ID = product_list_manager_pkg::BLANK_ID
) (
  input  logic                                            CLK,
  input  logic                                            RST,
  input  logic                                            add_valid,
  input  logic [product_list_manager_pkg::SLOT_W-1:0]     add_id,
  output logic                                            add_ready,
  input  logic                                            remove_last,
  input  logic                                            clear,
  output logic [SLOTS*product_list_manager_pkg::SLOT_W-1:0] product_IDS,
  output logic [product_list_manager_pkg::COUNT_W-1:0]    count,
  output logic [product_list_manager_pkg::TOTAL_W-1:0]    total,
  output logic                                            full,
  output logic                                            empty,
  output logic                                            err
);

  import product_list_manager_pkg::SLOT_W;
  import product_list_manager_pkg::PRICE_W;
  import product_list_manager_pkg::TOTAL_W;
  import product_list_manager_pkg::COUNT_W;
  import product_list_manager_pkg::ST_IDLE;
  import product_list_manager_pkg::ST_CLR;

  logic [SLOT_W-1:0]  slots_r [SLOTS];
  logic [COUNT_W-1:0] count_r;
  logic [TOTAL_W-1:0] total_r;
  logic [0:0]         state_r;
  logic               err_r;

  logic               full_s;
  logic               do_clear_s;
  logic               do_remove_s;
  logic               do_add_s;
  logic               reject_s;
  logic [0:0]         state_nxt_s;
  logic [COUNT_W-1:0] rem_idx_s;
  logic [SLOT_W-1:0]  rem_id_s;
  logic [PRICE_W-1:0] add_price_s;
  logic [PRICE_W-1:0] rem_price_s;

  assign full_s    = (count_r == COUNT_W'(SLOTS));
  assign rem_idx_s = count_r - 4'd1;

  price_table u_add_price (.id(add_id),   .price(add_price_s));
  price_table u_rem_price (.id(rem_id_s), .price(rem_price_s));

  // Select the newest occupied slot without indexing past the array on an empty list
  always_comb begin
    rem_id_s = BLANK_ID;
    for (int i = 0; i < SLOTS; i++) begin
      if (rem_idx_s == COUNT_W'(i)) begin
        rem_id_s = slots_r[i];
      end else begin
        rem_id_s = rem_id_s;
      end
    end
  end

  // Arbitrate requests (clear > remove_last > add) and flag rejected operations
  always_comb begin
    do_clear_s  = 1'b0;
    do_remove_s = 1'b0;
    do_add_s    = 1'b0;
    reject_s    = 1'b0;
    state_nxt_s = ST_IDLE;
    if (state_r == ST_IDLE) begin
      if (clear) begin
        do_clear_s  = 1'b1;
        state_nxt_s = ST_CLR;
      end else if (remove_last) begin
        if (count_r != 4'd0) begin
          do_remove_s = 1'b1;
        end else begin
          reject_s = 1'b1;
        end
      end else if (add_valid) begin
        if ((add_id == BLANK_ID) || full_s) begin
          reject_s = 1'b1;
        end else begin
          do_add_s = 1'b1;
        end
      end else begin
        reject_s = 1'b0;
      end
    end else begin
      state_nxt_s = ST_IDLE;
    end
  end

  // Slot contents, occupancy, running total, state and error pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SLOTS; i++) begin
        slots_r[i] <= BLANK_ID;
      end
      count_r <= 4'd0;
      total_r <= 12'd0;
      state_r <= ST_IDLE;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      err_r   <= reject_s;
      for (int i = 0; i < SLOTS; i++) begin
        if (do_clear_s) begin
          slots_r[i] <= BLANK_ID;
        end else if (do_remove_s && (rem_idx_s == COUNT_W'(i))) begin
          slots_r[i] <= BLANK_ID;
        end else if (do_add_s && (count_r == COUNT_W'(i))) begin
          slots_r[i] <= add_id;
        end else begin
          slots_r[i] <= slots_r[i];
        end
      end
      if (do_clear_s) begin
        count_r <= 4'd0;
        total_r <= 12'd0;
      end else if (do_remove_s) begin
        count_r <= count_r - 4'd1;
        total_r <= total_r - TOTAL_W'(rem_price_s);
      end else if (do_add_s) begin
        count_r <= count_r + 4'd1;
        total_r <= total_r + TOTAL_W'(add_price_s);
      end else begin
        count_r <= count_r;
        total_r <= total_r;
      end
    end
  end

  // Slot 0 (oldest) sits in the most significant nibble
  always_comb begin
    product_IDS = {(SLOTS*SLOT_W){1'b0}};
    for (int i = 0; i < SLOTS; i++) begin
      product_IDS[(SLOTS-1-i)*SLOT_W +: SLOT_W] = slots_r[i];
    end
  end

  assign count     = count_r;
  assign total     = total_r;
  assign err       = err_r;
  assign full      = full_s;
  assign empty     = (count_r == 4'd0);
  assign add_ready = !full_s && (state_r == ST_IDLE);

endmodule

// File: tb/tb_product_list_manager.sv
// Self-checking bench for product_list_manager: directed scenarios followed by random
// traffic, all checked against a queue-based model of the product list.
module tb_product_list_manager;

  logic        CLK;
  logic        RST;
  logic        add_valid;
  logic [3:0]  add_id;
  logic        add_ready;
  logic        remove_last;
  logic        clear;
  logic [47:0] product_IDS;
  logic [3:0]  count;
  logic [11:0] total;
  logic        full;
  logic        empty;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  int price_of [16] = '{10, 25, 40, 55, 99, 120, 7, 200, 33, 64, 128, 150, 1, 180, 255, 0};

  int m_list [$];
  bit m_in_clr;
  bit m_err;

  product_list_manager dut (
    .CLK(CLK), .RST(RST), .add_valid(add_valid), .add_id(add_id), .add_ready(add_ready),
    .remove_last(remove_last), .clear(clear), .product_IDS(product_IDS), .count(count),
    .total(total), .full(full), .empty(empty), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] exp_ids();
    logic [47:0] v;
    for (int i = 0; i < 12; i++) begin
      v[47-4*i -: 4] = (i < m_list.size()) ? 4'(m_list[i]) : 4'hF;
    end
    return v;
  endfunction

  function automatic int exp_total();
    int s = 0;
    foreach (m_list[i]) s += price_of[m_list[i]];
    return s;
  endfunction

  task automatic model_reset();
    m_list.delete();
    m_in_clr = 1'b0;
    m_err    = 1'b0;
  endtask

  // Apply the list rules to the inputs presented for the coming edge
  task automatic model_step();
    m_err = 1'b0;
    if (m_in_clr) begin
      m_in_clr = 1'b0;
    end else if (clear) begin
      m_list.delete();
      m_in_clr = 1'b1;
    end else if (remove_last) begin
      if (m_list.size() > 0) void'(m_list.pop_back());
      else m_err = 1'b1;
    end else if (add_valid) begin
      if (add_id == 4'hF || m_list.size() == 12) m_err = 1'b1;
      else m_list.push_back(int'(add_id));
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ids"},   64'(product_IDS), 64'(exp_ids()));
    chk({tag, ".count"}, 64'(count), 64'(m_list.size()));
    chk({tag, ".total"}, 64'(total), 64'(exp_total()));
    chk({tag, ".full"},  64'(full),  64'(m_list.size() == 12));
    chk({tag, ".empty"}, 64'(empty), 64'(m_list.size() == 0));
    chk({tag, ".ready"}, 64'(add_ready), 64'((m_list.size() < 12) && !m_in_clr));
    chk({tag, ".err"},   64'(err),   64'(m_err));
  endtask

  // Inputs are already set (at a negedge); advance one edge and check at the next negedge
  task automatic cycle(input string tag);
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    add_valid = 1'b0; add_id = 4'h0; remove_last = 1'b0; clear = 1'b0;
  endtask

  task automatic do_add(input logic [3:0] id, input string tag);
    idle_inputs(); add_valid = 1'b1; add_id = id;
    cycle(tag);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    model_reset();
    #23;
    chk("reset.ids",   64'(product_IDS), 64'h0000_FFFF_FFFF_FFFF);
    chk("reset.count", 64'(count), 64'd0);
    chk("reset.total", 64'(total), 64'd0);
    chk("reset.err",   64'(err),   64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_all("idle");

    // Appends of 3, 7, 1
    do_add(4'd3, "add3");
    do_add(4'd7, "add7");
    do_add(4'd1, "add1");
    chk("three.head",  64'(product_IDS[47:36]), 64'h371);
    chk("three.tail",  64'(product_IDS[35:0]),  64'hF_FFFF_FFFF);
    chk("three.total", 64'(total), 64'd280);

    // Drop newest, then empty the list and remove once more
    remove_last = 1'b1; cycle("rm1"); idle_inputs();
    chk("rm1.slot2", 64'(product_IDS[39:36]), 64'hF);
    chk("rm1.total", 64'(total), 64'd255);
    remove_last = 1'b1; cycle("rm2");
    cycle("rm3"); idle_inputs();
    remove_last = 1'b1; cycle("rm_empty"); idle_inputs();
    chk("rm_empty.err", 64'(err), 64'd1);
    cycle("rm_empty_after");

    // Blank ID is rejected
    do_add(4'hF, "addF");
    chk("addF.count", 64'(count), 64'd0);

    // Fill to 12 with the priciest ID, then a 13th
    for (int i = 0; i < 12; i++) do_add(4'd14, "fill");
    chk("fill.total", 64'(total), 64'd3060);
    do_add(4'd2, "overfill");
    chk("overfill.err", 64'(err), 64'd1);
    cycle("overfill_after");

    // Clear together with an add of 5
    clear = 1'b1; add_valid = 1'b1; add_id = 4'd5;
    cycle("clr_add"); idle_inputs();
    chk("clr_add.ready", 64'(add_ready), 64'd0);
    cycle("clr_done");
    chk("clr_done.ready", 64'(add_ready), 64'd1);

    // Simultaneous remove and add on a non-empty list: remove wins, no err
    do_add(4'd9, "pre_pri");
    remove_last = 1'b1; add_valid = 1'b1; add_id = 4'hF;
    cycle("pri_rm_add"); idle_inputs();

    // Reset between edges while an append is presented
    do_add(4'd8, "pre_rst");
    add_valid = 1'b1; add_id = 4'd4;
    #2 RST = 1'b1;
    #1;
    chk("midrst.ids",   64'(product_IDS), 64'h0000_FFFF_FFFF_FFFF);
    chk("midrst.count", 64'(count), 64'd0);
    chk("midrst.total", 64'(total), 64'd0);
    chk("midrst.err",   64'(err),   64'd0);
    model_reset();
    idle_inputs();
    @(negedge CLK);
    RST = 1'b0;
    do_add(4'd6, "post_rst");
    chk("post_rst.slot0", 64'(product_IDS[47:44]), 64'h6);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      clear       = ($urandom_range(0, 99) < 4);
      remove_last = ($urandom_range(0, 99) < 22);
      add_valid   = ($urandom_range(0, 99) < 75);
      add_id      = 4'($urandom_range(0, 15));
      cycle("rand");
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
